// File: rtl/svn_capture.sv
// svn_capture: recovers the hex value shown on a multiplexed 8-digit,
// 7-segment display by watching its active-low anode and cathode lines.
// Each {an,seg} pattern must stay stable for SETTLE cycles before it is
// captured once. A capture decodes the segments into the selected digit.
module svn_capture #(
  parameter int SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  an,
  input  logic [6:0]  seg,
  input  logic        clr,
  output logic [31:0] digits,
  output logic [7:0]  dvalid,
  output logic        frame_done,
  output logic        seg_err,
  output logic        an_err
);

  localparam logic [14:0] IDLE   = {8'hFF, 7'h7F};
  localparam logic [7:0]  CAP_AT = 8'(SETTLE - 1);
  localparam logic [7:0]  SAT    = 8'(SETTLE);

  logic [14:0] in_q;
  logic [14:0] in_qq;
  logic [7:0]  cnt;
  logic [7:0]  seen;

  logic [7:0]  sel;
  logic [6:0]  q_seg;
  logic        capture;
  logic        multi_low;
  logic        one_low;
  logic        cap_one;
  logic        cap_multi;
  logic [3:0]  dec;
  logic        dec_ok;
  logic [7:0]  seen_set;
  logic        frame_hit;
  logic [31:0] digits_next;
  logic [7:0]  dvalid_next;

  // Sample the pins, keep the previous sample, and count the dwell time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q  <= IDLE;
      in_qq <= IDLE;
      cnt   <= 8'd0;
    end else begin
      in_q  <= {an, seg};
      in_qq <= in_q;
      if (in_q != in_qq) begin
        cnt <= 8'd0;
      end else if (cnt != SAT) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // Anode lines are active-low, so invert them to get a select mask.
  assign sel       = ~in_q[14:7];
  assign q_seg     = in_q[6:0];
  // cnt saturates at SETTLE, so it only passes SETTLE-1 once per dwell.
  assign capture   = (cnt == CAP_AT) && (in_q == in_qq);
  assign multi_low = (sel & (sel - 8'd1)) != 8'd0;
  assign one_low   = (sel != 8'd0) && !multi_low;
  // clr overrides a capture in the same cycle, including its pulses.
  assign cap_one   = capture && one_low && !clr;
  assign cap_multi = capture && multi_low && !clr;

  // Decode the active-low segment pattern {CA..CG} into a hex nibble.
  always_comb begin
    dec    = 4'h0;
    dec_ok = 1'b1;
    case (q_seg)
      7'b0000001: dec = 4'h0;
      7'b1001111: dec = 4'h1;
      7'b0010010: dec = 4'h2;
      7'b0000110: dec = 4'h3;
      7'b1001100: dec = 4'h4;
      7'b0100100: dec = 4'h5;
      7'b0100000: dec = 4'h6;
      7'b0001111: dec = 4'h7;
      7'b0000000: dec = 4'h8;
      7'b0000100: dec = 4'h9;
      7'b1110010: dec = 4'hA;
      7'b1100110: dec = 4'hB;
      7'b1011100: dec = 4'hC;
      7'b0110100: dec = 4'hD;
      7'b1100000: dec = 4'hE;
      7'b1111111: dec = 4'hF;
      default:    dec_ok = 1'b0;
    endcase
  end

  // A digit counts as seen even when its pattern was undecodable.
  assign seen_set  = seen | (cap_one ? sel : 8'h00);
  assign frame_hit = cap_one && (seen_set == 8'hFF);

  // Per-digit next values: only the single selected digit changes, and a
  // bad pattern keeps the old nibble but drops its valid flag.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_digit
      assign digits_next[4*gi +: 4] = (cap_one && sel[gi] && dec_ok) ? dec
                                                                    : digits[4*gi +: 4];
      assign dvalid_next[gi]        = (cap_one && sel[gi]) ? dec_ok : dvalid[gi];
    end
  endgenerate

  // Captured data, frame tracking and the one-cycle event pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digits     <= 32'd0;
      dvalid     <= 8'd0;
      seen       <= 8'd0;
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
      an_err     <= 1'b0;
    end else if (clr) begin
      digits     <= 32'd0;
      dvalid     <= 8'd0;
      seen       <= 8'd0;
      frame_done <= 1'b0;
      seg_err    <= 1'b0;
      an_err     <= 1'b0;
    end else begin
      digits     <= digits_next;
      dvalid     <= dvalid_next;
      seen       <= frame_hit ? 8'd0 : seen_set;
      frame_done <= frame_hit;
      seg_err    <= cap_one && !dec_ok;
      an_err     <= cap_multi;
    end
  end

endmodule

// File: tb/tb_svn_capture.sv
// Directed bench for svn_capture with SETTLE=4: latency, full frame scan,
// bad segment patterns, anode conflicts, short dwells, clear and reset.
module tb_svn_capture;

  logic        clk;
  logic        rst_n;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        clr;
  logic [31:0] digits;
  logic [7:0]  dvalid;
  logic        frame_done;
  logic        seg_err;
  logic        an_err;

  int checks_total  = 0;
  int checks_passed = 0;
  int fd_n = 0;
  int se_n = 0;
  int ae_n = 0;

  logic [6:0] enc [16];

  svn_capture #(.SETTLE(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .an         (an),
    .seg        (seg),
    .clr        (clr),
    .digits     (digits),
    .dvalid     (dvalid),
    .frame_done (frame_done),
    .seg_err    (seg_err),
    .an_err     (an_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count pulses, sampled half a cycle away from the active edge.
  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_n++;
    if (seg_err === 1'b1)    se_n++;
    if (an_err === 1'b1)     ae_n++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) begin
      checks_passed++;
      $display("check %-14s observed %h expected %h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    an  = 8'hFF;
    seg = 7'h7F;
    step(n);
  endtask

  initial begin
    enc[0]  = 7'b0000001; enc[1]  = 7'b1001111; enc[2]  = 7'b0010010; enc[3]  = 7'b0000110;
    enc[4]  = 7'b1001100; enc[5]  = 7'b0100100; enc[6]  = 7'b0100000; enc[7]  = 7'b0001111;
    enc[8]  = 7'b0000000; enc[9]  = 7'b0000100; enc[10] = 7'b1110010; enc[11] = 7'b1100110;
    enc[12] = 7'b1011100; enc[13] = 7'b0110100; enc[14] = 7'b1100000; enc[15] = 7'b1111111;

    rst_n = 1'b0;
    clr   = 1'b0;
    an    = 8'hFF;
    seg   = 7'h7F;
    step(2);
    chk("rst_digits", digits, 32'h0);
    chk("rst_dvalid", {24'h0, dvalid}, 32'h0);
    chk("rst_pulses", {29'h0, frame_done, seg_err, an_err}, 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Single digit: capture lands on the 6th edge after the change.
    an  = 8'hFE;
    seg = enc[2];
    step(5);
    chk("lat_early", {24'h0, dvalid}, 32'h0);
    step(1);
    chk("lat_digits", digits, 32'h0000_0002);
    chk("lat_dvalid", {24'h0, dvalid}, 32'h01);
    step(4);
    chk("lat_pulses", fd_n + se_n + ae_n, 32'd0);
    idle(3);

    // Full scan of digits 0..7 with values 1..8.
    for (int i = 0; i < 8; i++) begin
      an  = ~(8'h01 << i);
      seg = enc[i+1];
      if (i == 7) begin
        step(5);
        chk("fd_early", {31'h0, frame_done}, 32'h0);
        step(1);
        chk("fd_edge", {31'h0, frame_done}, 32'h1);
        chk("scan_digits", digits, 32'h8765_4321);
        chk("scan_dvalid", {24'h0, dvalid}, 32'hFF);
        step(1);
        chk("fd_one_cycle", {31'h0, frame_done}, 32'h0);
        step(3);
      end else begin
        step(10);
      end
      idle(2);
    end
    chk("fd_count", fd_n, 32'd1);

    // Undecodable pattern on digit 3.
    an  = 8'hF7;
    seg = 7'b1111110;
    step(10);
    chk("segerr_count", se_n, 32'd1);
    chk("segerr_dvalid", {24'h0, dvalid}, 32'hF7);
    chk("segerr_digits", digits, 32'h8765_4321);
    idle(3);

    // Two anodes low: an_err only.
    an  = 8'hFC;
    seg = enc[5];
    step(10);
    chk("anerr_count", ae_n, 32'd1);
    chk("anerr_digits", digits, 32'h8765_4321);
    chk("anerr_dvalid", {24'h0, dvalid}, 32'hF7);
    idle(3);

    // Dwells of 3 and 4 cycles are too short to capture.
    an  = 8'hFB;
    seg = enc[9];
    step(3);
    idle(5);
    an  = 8'hFB;
    seg = enc[9];
    step(4);
    idle(5);
    chk("short_digits", digits, 32'h8765_4321);
    chk("short_pulses", se_n + ae_n + fd_n, 32'd3);

    // clr coinciding with a capture wins.
    an  = 8'hFD;
    seg = enc[10];
    step(5);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("clr_digits", digits, 32'h0);
    chk("clr_dvalid", {24'h0, dvalid}, 32'h0);
    step(4);
    chk("clr_norecap", {24'h0, dvalid}, 32'h0);
    chk("clr_pulses", se_n + ae_n + fd_n, 32'd3);
    idle(3);

    // Reset at cnt=2 discards the dwell; a full dwell follows release.
    an  = 8'hFE;
    seg = enc[7];
    step(4);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(5);
    chk("rst_mid_none", {24'h0, dvalid}, 32'h0);
    step(1);
    chk("rst_mid_dig", digits, 32'h0000_0007);
    chk("rst_mid_dv", {24'h0, dvalid}, 32'h01);
    idle(3);

    // Re-capture of digit 0 overwrites only nibble 0.
    an  = 8'hFE;
    seg = enc[14];
    step(10);
    chk("recap_digits", digits, 32'h0000_000E);
    chk("recap_pulses", se_n + ae_n + fd_n, 32'd3);
    idle(2);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/svn_capture.md
SVN_CAPTURE -- requirements
Module: svn_capture

Interface
REQ-001 Parameter SETTLE, default 4: cycles a pattern must be stable before capture; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 an  input  8  anode enables, active-low; an[i]=0 selects digit i.
REQ-005 seg  input  7  segment cathodes {CA,CB,CC,CD,CE,CF,CG}, active-low, CA in bit 6.
REQ-006 clr  input  1  synchronous clear of captured data, active-high.
REQ-007 digits  output  32  captured hex value; digit i in bits [4i+3:4i].
REQ-008 dvalid  output  8  dvalid[i]=1: digits nibble i holds a legally decoded pattern.
REQ-009 frame_done  output  1  one-cycle pulse when all 8 digits have been captured since the last frame_done/clr/reset.
REQ-010 seg_err  output  1  one-cycle pulse on capture of an undecodable segment pattern.
REQ-011 an_err  output  1  one-cycle pulse when a stable an has two or more bits low.

Function
REQ-012 Block shall register {an,seg} into in_q each cycle and keep previous sample in_qq; no logic shall use raw inputs.
REQ-013 Counter cnt shall clear to 0 when in_q != in_qq, else increment, saturating at SETTLE.
REQ-014 Capture event shall occur in the cycle cnt==SETTLE-1 and in_q==in_qq; exactly one capture per dwell, no re-capture while the pattern is unchanged.
REQ-015 At capture with exactly one low bit i in an: decode seg and update outputs on that edge.
REQ-016 Decode table (seg -> nibble): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0000100->9, 1110010->A, 1100110->B, 1011100->C, 0110100->D, 1100000->E, 1111111->F.
REQ-017 Legal pattern: digits[4i+3:4i] <= nibble, dvalid[i] <= 1, internal seen[i] <= 1.
REQ-018 Any other pattern: seg_err pulses, dvalid[i] <= 0, nibble unchanged, seen[i] <= 1.
REQ-019 At capture with an==8'hFF: no update, no error (blanking interval).
REQ-020 At capture with two or more an bits low: an_err pulses; digits, dvalid, seen unchanged.
REQ-021 When a capture makes seen==8'hFF, frame_done shall pulse on that same edge and seen shall clear to 0; dvalid and digits retained.
REQ-022 Latency: inputs changed and then held constant shall update digits/dvalid on the (SETTLE+2)th rising edge after the change.
REQ-023 A pattern held fewer than SETTLE+1 sampled cycles shall produce no capture and no pulse.
REQ-024 clr=1 shall set digits, dvalid, seen to 0 on that edge and override a coincident capture (no pulses that cycle); cnt unaffected.
REQ-025 Digits captured in any order and repeatedly; re-capture of digit i before frame end overwrites nibble i only.

Reset
REQ-026 rst_n=0 at a rising edge shall set digits=0, dvalid=0, seen=0, cnt=0, in_q=in_qq={8'hFF,7'h7F}, frame_done=seg_err=an_err=0.
REQ-027 Reset asserted mid-dwell shall discard the pending capture; after release a full SETTLE dwell is required.
REQ-028 rst_n has priority over clr and capture.

Verification
REQ-029 SETTLE=4; an=8'hFE, seg=7'b0010010 held -> 6th edge: digits[3:0]=2, dvalid=8'h01, no pulses.
REQ-030 Scan digits 0..7 with values 1..8, 10 cycles each, 2-cycle an=FF gap -> digits=32'h87654321, dvalid=FF, single frame_done on digit-7 capture edge.
REQ-031 an=8'hF7, seg=7'b1111110 held -> one seg_err pulse, dvalid[3]=0, digits[15:12] unchanged.
REQ-032 an=8'hFC held 10 cycles -> one an_err pulse, no data change; an=8'hFB held 3 cycles -> nothing.
REQ-033 clr asserted same cycle as capture -> digits=0, dvalid=0, no frame_done/seg_err.
REQ-034 rst_n low for 1 cycle at cnt=2 -> no capture; capture occurs SETTLE+2 edges after reset release with inputs held.
